gpu_line_engine: RTL and testbench

- Line rasterizer that answers gpu_controller's line dispatch.
- Samples run_line and the command fields (endpoints, colour), walks the line with integer Bresenham, and emits one pixel per handshake to the framebuffer writer.
- Pulses finished_line back to the controller, which then pops the command FIFO.

---
 rtl/gpu_line_engine.sv | 176 +++++++++++++++++
 tb/tb_gpu_line_engine.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_line_engine.sv
// Bresenham line rasterizer: latches a line command from the controller, walks the line one
// point per cycle and emits pixels over a valid/ready handshake, then pulses finished_line_o.
// Optional macro LINE_CLIP_EN: points outside SCREEN_W x SCREEN_H are stepped silently.
module gpu_line_engine #(
  parameter int unsigned WIDTH_BITS   = 10,
  parameter int unsigned HEIGHT_BITS  = 9,
  parameter int unsigned CHANNEL_BITS = 8,
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SCREEN_H     = 480
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    run_line_i,
  input  logic [WIDTH_BITS-1:0]   x1_i,
  input  logic [HEIGHT_BITS-1:0]  y1_i,
  input  logic [WIDTH_BITS-1:0]   x2_i,
  input  logic [HEIGHT_BITS-1:0]  y2_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  input  logic                    px_ready_i,
  output logic                    px_valid_o,
  output logic [WIDTH_BITS-1:0]   px_x_o,
  output logic [HEIGHT_BITS-1:0]  px_y_o,
  output logic [CHANNEL_BITS-1:0] px_r_o,
  output logic [CHANNEL_BITS-1:0] px_g_o,
  output logic [CHANNEL_BITS-1:0] px_b_o,
  output logic                    finished_line_o,
  output logic                    busy_o
);

  // Error term width: one sign bit plus one guard bit over the widest coordinate.
  localparam int unsigned CW = ((WIDTH_BITS > HEIGHT_BITS) ? WIDTH_BITS : HEIGHT_BITS) + 2;

  typedef enum logic [2:0] {StIdle, StSetup, StDraw, StDone, StWaitLow} state_e;

  state_e                   state_q;
  logic [WIDTH_BITS-1:0]    x1_q, x2_q, cur_x_q;
  logic [HEIGHT_BITS-1:0]   y1_q, y2_q, cur_y_q;
  logic [CHANNEL_BITS-1:0]  r_q, g_q, b_q;
  logic signed [CW-1:0]     dx_q, dy_q, err_q;
  logic                     sx_neg_q, sy_neg_q;
  logic                     px_valid_q, finished_q;

  logic [CW-1:0]            dx_abs, dy_abs;
  logic signed [CW-1:0]     dy_s, err_s, err_nxt;
  logic signed [CW:0]       e2, dx_e, dy_e;
  logic                     step_x, step_y, at_end, advance;
  logic [WIDTH_BITS-1:0]    nxt_x;
  logic [HEIGHT_BITS-1:0]   nxt_y;
  logic                     cur_off, nxt_off, start_off;

  // Setup arithmetic from the latched endpoints.
  always_comb begin
    dx_abs = (x2_q > x1_q) ? CW'(x2_q - x1_q) : CW'(x1_q - x2_q);
    dy_abs = (y2_q > y1_q) ? CW'(y2_q - y1_q) : CW'(y1_q - y2_q);
    dy_s   = CW'(0) - dy_abs;
    err_s  = dx_abs + dy_s;
  end

  // One Bresenham step from the current point; both axes may move together.
  always_comb begin
    e2      = {err_q, 1'b0};
    dx_e    = {dx_q[CW-1], dx_q};
    dy_e    = {dy_q[CW-1], dy_q};
    step_x  = (e2 >= dy_e);
    step_y  = (e2 <= dx_e);
    err_nxt = err_q;
    nxt_x   = cur_x_q;
    nxt_y   = cur_y_q;
    if (step_x) begin
      err_nxt = err_nxt + dy_q;
      nxt_x   = sx_neg_q ? cur_x_q - WIDTH_BITS'(1) : cur_x_q + WIDTH_BITS'(1);
    end
    if (step_y) begin
      err_nxt = err_nxt + dx_q;
      nxt_y   = sy_neg_q ? cur_y_q - HEIGHT_BITS'(1) : cur_y_q + HEIGHT_BITS'(1);
    end
  end

`ifdef LINE_CLIP_EN
  assign cur_off   = (32'(cur_x_q) >= SCREEN_W) || (32'(cur_y_q) >= SCREEN_H);
  assign nxt_off   = (32'(nxt_x) >= SCREEN_W) || (32'(nxt_y) >= SCREEN_H);
  assign start_off = (32'(x1_q) >= SCREEN_W) || (32'(y1_q) >= SCREEN_H);
`else
  assign cur_off   = 1'b0;
  assign nxt_off   = 1'b0;
  assign start_off = 1'b0;
`endif

  assign at_end  = (cur_x_q == x2_q) && (cur_y_q == y2_q);
  // Off-screen points step without waiting for the writer.
  assign advance = (px_valid_q & px_ready_i) | cur_off;

  // Line FSM with registered datapath and outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      x1_q       <= '0;
      y1_q       <= '0;
      x2_q       <= '0;
      y2_q       <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      err_q      <= '0;
      sx_neg_q   <= 1'b0;
      sy_neg_q   <= 1'b0;
      px_valid_q <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          finished_q <= 1'b0;
          if (run_line_i) begin
            x1_q    <= x1_i;
            y1_q    <= y1_i;
            x2_q    <= x2_i;
            y2_q    <= y2_i;
            r_q     <= r_i;
            g_q     <= g_i;
            b_q     <= b_i;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          dx_q       <= dx_abs;
          dy_q       <= dy_s;
          err_q      <= err_s;
          sx_neg_q   <= !(x1_q < x2_q);
          sy_neg_q   <= !(y1_q < y2_q);
          cur_x_q    <= x1_q;
          cur_y_q    <= y1_q;
          px_valid_q <= ~start_off;
          state_q    <= StDraw;
        end
        StDraw: begin
          if (advance) begin
            if (at_end) begin
              px_valid_q <= 1'b0;
              finished_q <= 1'b1;
              state_q    <= StDone;
            end else begin
              cur_x_q    <= nxt_x;
              cur_y_q    <= nxt_y;
              err_q      <= err_nxt;
              px_valid_q <= ~nxt_off;
            end
          end
        end
        StDone: begin
          finished_q <= 1'b0;
          state_q    <= StWaitLow;
        end
        StWaitLow: begin
          if (!run_line_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign px_valid_o      = px_valid_q;
  assign px_x_o          = cur_x_q;
  assign px_y_o          = cur_y_q;
  assign px_r_o          = r_q;
  assign px_g_o          = g_q;
  assign px_b_o          = b_q;
  assign finished_line_o = finished_q;
  assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_gpu_line_engine.sv
// Directed bench for gpu_line_engine: line shapes, backpressure, held run, reset mid-line.
module tb_gpu_line_engine;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       run_line_i = 1'b0;
  logic [9:0] x1_i = '0, x2_i = '0;
  logic [8:0] y1_i = '0, y2_i = '0;
  logic [7:0] r_i = '0, g_i = '0, b_i = '0;
  logic       px_ready_i = 1'b1;
  logic       px_valid_o, finished_line_o, busy_o;
  logic [9:0] px_x_o;
  logic [8:0] px_y_o;
  logic [7:0] px_r_o, px_g_o, px_b_o;

  int checks = 0;
  int errors = 0;

  int          px_q[$], py_q[$], pc_q[$], sx_q[$], sy_q[$];
  logic [23:0] col_q[$];
  int          fin_cnt, fin_cyc, first_cyc;
  bit          timeout;

  gpu_line_engine dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .run_line_i      (run_line_i),
    .x1_i            (x1_i),
    .y1_i            (y1_i),
    .x2_i            (x2_i),
    .y2_i            (y2_i),
    .r_i             (r_i),
    .g_i             (g_i),
    .b_i             (b_i),
    .px_ready_i      (px_ready_i),
    .px_valid_o      (px_valid_o),
    .px_x_o          (px_x_o),
    .px_y_o          (px_y_o),
    .px_r_o          (px_r_o),
    .px_g_o          (px_g_o),
    .px_b_o          (px_b_o),
    .finished_line_o (finished_line_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Drives one command and records accepted pixels, stalled pixels and finished pulses.
  // cyc counts negedges after the command was presented (cyc 1 follows the sampling edge).
  task automatic run_line(input int ax, input int ay, input int bx, input int by,
                          input logic [23:0] col, input int stall_pix, input int stall_n,
                          input int hold);
    int cyc = 0;
    int stall_left = stall_n;
    int hold_left = -1;
    bit run_dropped = 1'b0;
    px_q.delete(); py_q.delete(); pc_q.delete(); sx_q.delete(); sy_q.delete(); col_q.delete();
    fin_cnt = 0; fin_cyc = -1; first_cyc = -1; timeout = 1'b0;
    @(negedge clk);
    x1_i = 10'(ax); y1_i = 9'(ay); x2_i = 10'(bx); y2_i = 9'(by);
    r_i = col[23:16]; g_i = col[15:8]; b_i = col[7:0];
    run_line_i = 1'b1;
    px_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (finished_line_o) begin
        fin_cnt++;
        fin_cyc = cyc;
        hold_left = hold;
      end
      if (hold_left == 0) begin
        run_line_i = 1'b0;
        run_dropped = 1'b1;
        hold_left = -1;
      end else if (hold_left > 0) begin
        hold_left--;
      end
      if (px_valid_o) begin
        if (px_q.size() == stall_pix && stall_left > 0) begin
          px_ready_i = 1'b0;
          stall_left--;
          sx_q.push_back(int'(px_x_o));
          sy_q.push_back(int'(px_y_o));
        end else begin
          px_ready_i = 1'b1;
          px_q.push_back(int'(px_x_o));
          py_q.push_back(int'(px_y_o));
          pc_q.push_back(cyc);
          col_q.push_back({px_r_o, px_g_o, px_b_o});
          if (first_cyc < 0) first_cyc = cyc;
        end
      end else begin
        px_ready_i = 1'b1;
      end
      if (run_dropped && !busy_o) break;
      if (cyc >= 300) begin
        timeout = 1'b1;
        run_line_i = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({px_valid_o, finished_line_o, busy_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got valid/fin/busy=%b required 000",
               {px_valid_o, finished_line_o, busy_o});
    end
    checks++;
    if ({px_x_o, px_y_o, px_r_o, px_g_o, px_b_o} !== 43'd0) begin
      errors++;
      $display("FAIL reset_data: got x=%0d y=%0d rgb=%h%h%h required all zero",
               px_x_o, px_y_o, px_r_o, px_g_o, px_b_o);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b required 0", busy_o);
    end
  endtask

  task automatic test_horizontal();
    run_line(0, 0, 3, 0, 24'h010203, -1, 0, 0);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL horiz_timeout: got timeout required completion");
    end
    checks++;
    if (px_q.size() != 4) begin
      errors++;
      $display("FAIL horiz_count: got %0d required 4", px_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (px_q[i] != i || py_q[i] != 0 || pc_q[i] != 2 + i || col_q[i] !== 24'h010203) begin
          errors++;
          $display("FAIL horiz_pix%0d: got (%0d,%0d) cyc %0d rgb %h required (%0d,0) cyc %0d rgb 010203",
                   i, px_q[i], py_q[i], pc_q[i], col_q[i], i, 2 + i);
        end
      end
    end
    checks++;
    if (first_cyc != 2) begin
      errors++;
      $display("FAIL horiz_latency: got first pixel at cyc %0d required 2", first_cyc);
    end
    checks++;
    if (fin_cnt != 1 || fin_cyc != 6) begin
      errors++;
      $display("FAIL horiz_finished: got %0d pulses at cyc %0d required 1 at cyc 6",
               fin_cnt, fin_cyc);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL horiz_busy_end: got %b required 0", busy_o);
    end
  endtask

  task automatic test_steep_reverse();
    int ex[5] = '{2, 1, 1, 0, 0};
    int ey[5] = '{4, 3, 2, 1, 0};
    run_line(2, 4, 0, 0, 24'hFF1000, -1, 0, 0);
    checks++;
    if (timeout !== 1'b0 || px_q.size() != 5 || fin_cnt != 1) begin
      errors++;
      $display("FAIL steep_count: got %0d pixels, %0d pulses, timeout %0b required 5, 1, 0",
               px_q.size(), fin_cnt, timeout);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (px_q[i] != ex[i] || py_q[i] != ey[i] || col_q[i] !== 24'hFF1000) begin
          errors++;
          $display("FAIL steep_pix%0d: got (%0d,%0d) rgb %h required (%0d,%0d) rgb ff1000",
                   i, px_q[i], py_q[i], col_q[i], ex[i], ey[i]);
        end
      end
    end
  endtask

  task automatic test_single_point();
    run_line(5, 5, 5, 5, 24'h0A0B0C, -1, 0, 0);
    checks++;
    if (timeout !== 1'b0 || px_q.size() != 1) begin
      errors++;
      $display("FAIL point_count: got %0d pixels timeout %0b required 1 pixel", px_q.size(),
               timeout);
    end else begin
      checks++;
      if (px_q[0] != 5 || py_q[0] != 5) begin
        errors++;
        $display("FAIL point_pix: got (%0d,%0d) required (5,5)", px_q[0], py_q[0]);
      end
    end
    checks++;
    if (fin_cnt != 1 || fin_cyc != 3) begin
      errors++;
      $display("FAIL point_finished: got %0d pulses at cyc %0d required 1 at cyc 3",
               fin_cnt, fin_cyc);
    end
  endtask

  task automatic test_backpressure();
    run_line(0, 0, 2, 2, 24'h112233, 1, 3, 0);
    checks++;
    if (timeout !== 1'b0 || px_q.size() != 3) begin
      errors++;
      $display("FAIL bp_count: got %0d pixels timeout %0b required 3", px_q.size(), timeout);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (px_q[i] != i || py_q[i] != i) begin
          errors++;
          $display("FAIL bp_pix%0d: got (%0d,%0d) required (%0d,%0d)", i, px_q[i], py_q[i], i, i);
        end
      end
      checks++;
      if (pc_q[1] != 6 || pc_q[2] != 7) begin
        errors++;
        $display("FAIL bp_timing: got accept cycs %0d,%0d required 6,7", pc_q[1], pc_q[2]);
      end
    end
    checks++;
    if (sx_q.size() != 3) begin
      errors++;
      $display("FAIL bp_stall_count: got %0d stalled samples required 3", sx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (sx_q[i] != 1 || sy_q[i] != 1) begin
          errors++;
          $display("FAIL bp_hold%0d: got (%0d,%0d) required (1,1)", i, sx_q[i], sy_q[i]);
        end
      end
    end
    checks++;
    if (fin_cnt != 1 || fin_cyc != 8) begin
      errors++;
      $display("FAIL bp_finished: got %0d pulses at cyc %0d required 1 at cyc 8",
               fin_cnt, fin_cyc);
    end
  endtask

  task automatic test_back_to_back();
    run_line(0, 0, 1, 0, 24'h000001, -1, 0, 2);
    checks++;
    if (timeout !== 1'b0 || fin_cnt != 1 || px_q.size() != 2) begin
      errors++;
      $display("FAIL hold_run: got %0d pulses %0d pixels timeout %0b required 1, 2, 0",
               fin_cnt, px_q.size(), timeout);
    end
    run_line(3, 3, 3, 4, 24'h000002, -1, 0, 0);
    checks++;
    if (timeout !== 1'b0 || fin_cnt != 1 || px_q.size() != 2) begin
      errors++;
      $display("FAIL restart: got %0d pulses %0d pixels timeout %0b required 1, 2, 0",
               fin_cnt, px_q.size(), timeout);
    end else begin
      checks++;
      if (px_q[0] != 3 || py_q[0] != 3 || px_q[1] != 3 || py_q[1] != 4
          || col_q[1] !== 24'h000002) begin
        errors++;
        $display("FAIL restart_pix: got (%0d,%0d),(%0d,%0d) rgb %h required (3,3),(3,4) 000002",
                 px_q[0], py_q[0], px_q[1], py_q[1], col_q[1]);
      end
    end
  endtask

  task automatic test_reset_mid_draw();
    int fins = 0;
    @(negedge clk);
    x1_i = 10'd0; y1_i = 9'd0; x2_i = 10'd9; y2_i = 9'd0;
    r_i = 8'h55; g_i = 8'h66; b_i = 8'h77;
    run_line_i = 1'b1;
    px_ready_i = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (px_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_draw: got valid %b required 1", px_valid_o);
    end
    #2;
    n_rst = 1'b0;
    run_line_i = 1'b0;
    #1;
    checks++;
    if ({px_valid_o, finished_line_o, busy_o, px_x_o, px_y_o, px_r_o, px_g_o, px_b_o} !== 46'd0)
    begin
      errors++;
      $display("FAIL rst_mid_outputs: got valid %b fin %b busy %b x %0d y %0d rgb %h%h%h required 0",
               px_valid_o, finished_line_o, busy_o, px_x_o, px_y_o, px_r_o, px_g_o, px_b_o);
    end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (finished_line_o) fins++;
    end
    checks++;
    if (fins != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: got %0d pulses busy %b required 0 pulses busy 0", fins,
               busy_o);
    end
  endtask

  task automatic test_screen_edge();
    int exp_n;
`ifdef LINE_CLIP_EN
    exp_n = 4;
`else
    exp_n = 8;
`endif
    run_line(636, 0, 643, 0, 24'h123456, -1, 0, 0);
    checks++;
    if (timeout !== 1'b0 || fin_cnt != 1 || px_q.size() != exp_n) begin
      errors++;
      $display("FAIL edge_count: got %0d pixels %0d pulses timeout %0b required %0d, 1, 0",
               px_q.size(), fin_cnt, timeout, exp_n);
    end else begin
      for (int i = 0; i < exp_n; i++) begin
        checks++;
        if (px_q[i] != 636 + i || py_q[i] != 0) begin
          errors++;
          $display("FAIL edge_pix%0d: got (%0d,%0d) required (%0d,0)", i, px_q[i], py_q[i],
                   636 + i);
        end
      end
      checks++;
      if (fin_cyc != 10) begin
        errors++;
        $display("FAIL edge_finished: got cyc %0d required 10", fin_cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_steep_reverse();
    test_single_point();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_draw();
    test_screen_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
